get_sched: RTL and testbench
============================

Name: get_sched

Overview:
- Round-robin scheduler that shares one get_ctrl sweep engine among NREQ requesters.
- Arbitrates pending requests and latches the winner's 2-D sweep bounds (inclusive final indices i/j).
- Issues a one-cycle get_v start pulse, then waits for get_fin and returns a per-requester done pulse.
- Includes a completion watchdog and a sticky error flag. Sits between the HPU command decode/requesters and get_ctrl.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 20, width of sweep bounds; matches get_ctrl addr_i/addr_j.
- TMO, 1048576, watchdog limit in WAIT cycles; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  grant enable; when low no new grant is made, and an in-flight job completes normally.
- req  in  NREQ  per-requester level request; held until its gnt.
- req_i  in  NREQ*W  packed final i bound; slice k belongs to requester k.
- req_j  in  NREQ*W  packed final j bound.
- gnt  out  NREQ  one-hot, one-cycle grant pulse.
- done  out  NREQ  one-hot, one-cycle completion pulse.
- get_v  out  1  start pulse to get_ctrl.
- addr_i  out  W  latched i bound to get_ctrl.
- addr_j  out  W  latched j bound to get_ctrl.
- get_fin  in  1  finish indication from get_ctrl; level, may stay high several cycles.
- busy  out  1  high from grant through the done cycle.
- act_id  out  $clog2(NREQ)  index of the granted requester; valid while busy.
- err  out  1  sticky watchdog error.
- clr_err  in  1  synchronous clear of err.

Behaviour:
- Reset (async assert, sync release): state IDLE; gnt, done, get_v, busy, err all 0; addr_i, addr_j, act_id 0; RR pointer 0; watchdog counter 0; get_fin history register 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If en and |req, select the first set req at or after pointer p, searching cyclically (p, p+1, ..., NREQ-1, 0, ...).
  - Next cycle enter ISSUE with: gnt[k]=1, get_v=1, busy=1, act_id=k, addr_i=req_i[k], addr_j=req_j[k].
  - Latency is 1 cycle from req sampled to gnt/get_v.
- ISSUE: lasts exactly 1 cycle; gnt and get_v drop; go to WAIT. addr_i/addr_j stay stable until the cycle after DONE.
- WAIT:
  - Completion is a rising edge of get_fin (get_fin=1 and previous get_fin=0), sampled only in WAIT.
  - A get_fin level left high from the previous job is ignored.
  - On completion go to DONE.
  - Watchdog counter is cleared on entry and increments each WAIT cycle. If TMO!=0 and the counter reaches TMO-1 without completion: set err and go to DONE.
- DONE:
  - done[act_id]=1 for 1 cycle; busy stays 1 this cycle.
  - Pointer p = (act_id+1) mod NREQ, wrapping at NREQ-1 to 0.
  - Next state is IDLE, with busy=0.
  - A new grant can therefore issue at the earliest 2 cycles after the done cycle (DONE -> IDLE -> ISSUE).
- Bounds are passed through unmodified. A value of 0 means a single iteration, since get_ctrl sweeps ini=0..fin inclusive. No width arithmetic other than the pointer modulo.
- req deasserting before its grant is legal: the request is simply not granted. req of the active requester is ignored while busy.
- err is sticky until clr_err=1. If clr_err and a timeout occur in the same cycle, set wins.
- en low in IDLE holds IDLE. en changes in other states have no effect.
- Async reset mid-job returns to IDLE immediately, with no done pulse. get_ctrl shares the reset domain, so both restart together.
- Simultaneous events:
  - get_fin rising in the same cycle as the watchdog limit counts as completion; err is not set.
  - A request arriving during DONE is sampled in IDLE on the next cycle.

Test Plan:
- Single request: req=0001, req_i=3, req_j=5.
  - Required: next cycle gnt=0001, get_v=1, addr_i=3, addr_j=5.
  - get_fin rising after 10 WAIT cycles -> done=0001 one cycle later, busy drops after that cycle.
- Round robin: req=1111 held, each job finished by a get_fin pulse.
  - Required: grant order 0,1,2,3,0.
  - With req=1010 and pointer 2: grant 3, then 1.
- Stale finish: get_fin held high from a previous job into the new ISSUE/WAIT.
  - Required: no done until get_fin falls and rises again.
- Watchdog: TMO=16, get_fin kept 0.
  - Required: err=1 and done pulse after 16 WAIT cycles.
  - clr_err -> err=0. Also check get_fin rising exactly on cycle 16 -> err stays 0.
- en gating / withdraw: en=0 with req=0100 -> no gnt for 20 cycles; en=1 -> gnt=0100 next cycle.
  - Also: req pulsed for 1 cycle while busy -> never granted.
- Reset mid-WAIT: rst_n low for 1 cycle.
  - Required: all outputs 0 immediately, pointer 0, and a following req=1000 is granted normally.

Source files
------------

// File: rtl/get_sched.sv
// get_sched: round-robin scheduler sharing one get_ctrl sweep engine among NREQ requesters.
// A winner's i/j bounds are latched and a start pulse is issued. The scheduler then waits for a
// fresh get_fin rising edge, or for the watchdog limit, and returns a per-requester done pulse.
module get_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 20,
  parameter int unsigned TMO  = 1048576
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       req_i,
  input  logic [NREQ*W-1:0]       req_j,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    get_v,
  output logic [W-1:0]            addr_i,
  output logic [W-1:0]            addr_j,
  input  logic                    get_fin,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] act_id,
  output logic                    err,
  input  logic                    clr_err
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [NREQ-1:0] gnt_d;
  logic [NREQ-1:0] done_d;
  logic            get_v_d;
  logic            busy_d;
  logic            err_d;
  logic [W-1:0]    addr_i_d;
  logic [W-1:0]    addr_j_d;
  logic [IW-1:0]   act_id_d;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_d;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_d;
  logic            fin_q;
  logic            fin_rise;
  logic            tmo_hit;
  logic            pick_vld;
  logic [IW-1:0]   pick_id;
  logic [IW-1:0]   scan_id;

  // (base + off) mod NREQ for off < NREQ
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    return IW'(sum);
  endfunction

  // Only a fresh low-to-high transition of get_fin counts as completion
  assign fin_rise = get_fin & ~fin_q;

  // Watchdog limit reached on this WAIT cycle (never when TMO is 0)
  assign tmo_hit = (TMO != 0) && (cnt == CW'(TMO - 1));

  // Cyclic search for the first pending request at or after the pointer
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    scan_id  = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      scan_id = wrap_add(ptr, off);
      if (!pick_vld && req[scan_id]) begin
        pick_vld = 1'b1;
        pick_id  = scan_id;
      end
    end
  end

  // Next-state and next-output logic; every output is loaded into a register below
  always_comb begin
    state_d  = state;
    gnt_d    = '0;
    done_d   = '0;
    get_v_d  = 1'b0;
    busy_d   = busy;
    addr_i_d = addr_i;
    addr_j_d = addr_j;
    act_id_d = act_id;
    ptr_d    = ptr;
    cnt_d    = cnt;
    err_d    = err & ~clr_err;

    case (state)
      IDLE: begin
        if (en && pick_vld) begin
          state_d         = ISSUE;
          gnt_d[pick_id]  = 1'b1;
          get_v_d         = 1'b1;
          busy_d          = 1'b1;
          act_id_d        = pick_id;
          addr_i_d        = req_i[32'(pick_id) * W +: W];
          addr_j_d        = req_j[32'(pick_id) * W +: W];
        end
      end

      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end

      WAIT: begin
        // A rising get_fin wins over a simultaneous watchdog expiry
        if (fin_rise) begin
          state_d        = DONE;
          done_d[act_id] = 1'b1;
        end else if (tmo_hit) begin
          state_d        = DONE;
          done_d[act_id] = 1'b1;
          err_d          = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ptr_d   = (act_id == IW'(NREQ - 1)) ? '0 : act_id + 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, output and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      done   <= '0;
      get_v  <= 1'b0;
      busy   <= 1'b0;
      addr_i <= '0;
      addr_j <= '0;
      act_id <= '0;
      ptr    <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      fin_q  <= 1'b0;
    end else begin
      state  <= state_d;
      gnt    <= gnt_d;
      done   <= done_d;
      get_v  <= get_v_d;
      busy   <= busy_d;
      addr_i <= addr_i_d;
      addr_j <= addr_j_d;
      act_id <= act_id_d;
      ptr    <= ptr_d;
      cnt    <= cnt_d;
      err    <= err_d;
      fin_q  <= get_fin;
    end
  end

endmodule

// File: tb/tb_get_sched.sv
// tb_get_sched: scenario bench for get_sched with a scoreboard of expected grant ids.
module tb_get_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 20;
  localparam int unsigned TMO  = 16;
  localparam int unsigned IW   = 2;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_i;
  logic [NREQ*W-1:0] req_j;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              get_v;
  logic [W-1:0]      addr_i;
  logic [W-1:0]      addr_j;
  logic              get_fin;
  logic              busy;
  logic [IW-1:0]     act_id;
  logic              err;
  logic              clr_err;

  logic [W-1:0] ri [NREQ];
  logic [W-1:0] rj [NREQ];

  int errors;
  int checks;
  int exp_q[$];

  get_sched #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .req_i   (req_i),
    .req_j   (req_j),
    .gnt     (gnt),
    .done    (done),
    .get_v   (get_v),
    .addr_i  (addr_i),
    .addr_j  (addr_j),
    .get_fin (get_fin),
    .busy    (busy),
    .act_id  (act_id),
    .err     (err),
    .clr_err (clr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pack per-requester bounds onto the flat buses
  always_comb begin
    for (int unsigned k = 0; k < NREQ; k++) begin
      req_i[k*W +: W] = ri[k];
      req_j[k*W +: W] = rj[k];
    end
  end

  function automatic logic [NREQ-1:0] oh(input int k);
    logic [NREQ-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    en      = 1'b1;
    req     = '0;
    get_fin = 1'b0;
    clr_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Wait up to budget negedges for a grant pulse
  task automatic wait_gnt(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (gnt != '0) seen = 1'b1;
    end
  endtask

  // From the ISSUE negedge: raise get_fin in WAIT cycle n, return at the following negedge
  task automatic fin_after(input int n);
    repeat (n) @(negedge clk);
    get_fin = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (gnt !== '0 || done !== '0 || get_v !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
        addr_i !== '0 || addr_j !== '0 || act_id !== '0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b done=%b get_v=%b busy=%b err=%b addr_i=%h addr_j=%h act_id=%0d, expected all zero",
               gnt, done, get_v, busy, err, addr_i, addr_j, act_id);
    end
  endtask

  task automatic test_single();
    bit seen;
    int k;
    req = 4'b0001;
    exp_q.push_back(0);
    wait_gnt(1, seen);
    k = exp_q.pop_front();
    checks++;
    if (!seen || gnt !== oh(k) || get_v !== 1'b1 || busy !== 1'b1 || act_id !== IW'(k) ||
        addr_i !== ri[k] || addr_j !== rj[k]) begin
      errors++;
      $display("FAIL single_grant: seen=%0d gnt=%b get_v=%b busy=%b id=%0d i=%h j=%h, expected gnt=%b id=%0d i=%h j=%h",
               seen, gnt, get_v, busy, act_id, addr_i, addr_j, oh(k), k, ri[k], rj[k]);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (gnt !== '0 || get_v !== 1'b0 || busy !== 1'b1 || addr_i !== ri[0] || addr_j !== rj[0]) begin
      errors++;
      $display("FAIL single_wait: gnt=%b get_v=%b busy=%b i=%h j=%h, expected 0000 0 1 %h %h",
               gnt, get_v, busy, addr_i, addr_j, ri[0], rj[0]);
    end
    fin_after(9);
    get_fin = 1'b0;
    checks++;
    if (done !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_done: done=%b busy=%b, expected 0001 1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: done=%b busy=%b, expected 0000 0", done, busy);
    end
  endtask

  task automatic test_round_robin();
    bit seen;
    int k;
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_gnt(3, seen);
      k = exp_q.pop_front();
      checks++;
      if (!seen || gnt !== oh(k) || act_id !== IW'(k) || addr_i !== ri[k] || addr_j !== rj[k]) begin
        errors++;
        $display("FAIL rr_grant%0d: seen=%0d gnt=%b id=%0d i=%h j=%h, expected gnt=%b id=%0d i=%h j=%h",
                 n, seen, gnt, act_id, addr_i, addr_j, oh(k), k, ri[k], rj[k]);
      end
      fin_after(3);
      get_fin = 1'b0;
      if (n == 4) req = '0;
      checks++;
      if (done !== oh(k)) begin
        errors++;
        $display("FAIL rr_done%0d: done=%b, expected %b", n, done, oh(k));
      end
    end
  endtask

  task automatic test_rr_pointer();
    bit seen;
    int k;
    do_reset();
    req = 4'b0010;
    exp_q.push_back(1);
    wait_gnt(3, seen);
    k = exp_q.pop_front();
    checks++;
    if (!seen || gnt !== oh(k)) begin
      errors++;
      $display("FAIL ptr_setup: seen=%0d gnt=%b, expected %b", seen, gnt, oh(k));
    end
    req = '0;
    fin_after(2);
    get_fin = 1'b0;
    req = 4'b1010;
    exp_q.push_back(3);
    exp_q.push_back(1);
    for (int n = 0; n < 2; n++) begin
      wait_gnt(3, seen);
      k = exp_q.pop_front();
      checks++;
      if (!seen || gnt !== oh(k) || act_id !== IW'(k)) begin
        errors++;
        $display("FAIL ptr_grant%0d: seen=%0d gnt=%b id=%0d, expected gnt=%b id=%0d",
                 n, seen, gnt, act_id, oh(k), k);
      end
      fin_after(2);
      get_fin = 1'b0;
    end
    req = '0;
  endtask

  task automatic test_stale_fin();
    bit seen;
    int k;
    int bad;
    do_reset();
    req = 4'b0001;
    exp_q.push_back(0);
    wait_gnt(3, seen);
    k = exp_q.pop_front();
    checks++;
    if (!seen || gnt !== oh(k)) begin
      errors++;
      $display("FAIL stale_first_grant: seen=%0d gnt=%b, expected %b", seen, gnt, oh(k));
    end
    fin_after(4);
    exp_q.push_back(0);
    wait_gnt(3, seen);
    k = exp_q.pop_front();
    req = '0;
    checks++;
    if (!seen || gnt !== oh(k) || get_fin !== 1'b1) begin
      errors++;
      $display("FAIL stale_second_grant: seen=%0d gnt=%b, expected %b", seen, gnt, oh(k));
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (done !== '0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stale_ignored: bad cycles=%0d, expected 0", bad);
    end
    get_fin = 1'b0;
    @(negedge clk);
    get_fin = 1'b1;
    @(negedge clk);
    get_fin = 1'b0;
    checks++;
    if (done !== 4'b0001) begin
      errors++;
      $display("FAIL stale_done: done=%b, expected 0001", done);
    end
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    bit seen;
    int k;
    int bad;
    do_reset();
    req = 4'b0001;
    exp_q.push_back(0);
    wait_gnt(3, seen);
    k = exp_q.pop_front();
    req = '0;
    checks++;
    if (!seen || gnt !== oh(k)) begin
      errors++;
      $display("FAIL wdog_grant: seen=%0d gnt=%b, expected %b", seen, gnt, oh(k));
    end
    bad = 0;
    repeat (16) begin
      @(negedge clk);
      if (done !== '0 || err !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wdog_early: bad cycles=%0d, expected 0", bad);
    end
    @(negedge clk);
    checks++;
    if (done !== 4'b0001 || err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wdog_expire: done=%b err=%b busy=%b, expected 0001 1 1", done, err, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== '0 || busy !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL wdog_sticky: done=%b busy=%b err=%b, expected 0000 0 1", done, busy, err);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL wdog_clear: err=%b, expected 0", err);
    end
    // get_fin rising on the last WAIT cycle counts as completion
    req = 4'b0001;
    exp_q.push_back(0);
    wait_gnt(3, seen);
    k = exp_q.pop_front();
    req = '0;
    fin_after(16);
    get_fin = 1'b0;
    checks++;
    if (!seen || done !== oh(k) || err !== 1'b0) begin
      errors++;
      $display("FAIL wdog_edge_fin: seen=%0d done=%b err=%b, expected %b 0", seen, done, err, oh(k));
    end
    @(negedge clk);
    // Timeout while clr_err is held: set wins
    req = 4'b0001;
    exp_q.push_back(0);
    wait_gnt(3, seen);
    k = exp_q.pop_front();
    req = '0;
    clr_err = 1'b1;
    repeat (17) @(negedge clk);
    checks++;
    if (!seen || done !== oh(k) || err !== 1'b1) begin
      errors++;
      $display("FAIL wdog_set_wins: seen=%0d done=%b err=%b, expected %b 1", seen, done, err, oh(k));
    end
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_en_gating();
    bit seen;
    int k;
    int bad;
    en  = 1'b0;
    req = 4'b0100;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (gnt !== '0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL en_hold: bad cycles=%0d, expected 0", bad);
    end
    en = 1'b1;
    exp_q.push_back(2);
    wait_gnt(1, seen);
    k = exp_q.pop_front();
    req = '0;
    checks++;
    if (!seen || gnt !== oh(k) || addr_i !== ri[k] || addr_j !== rj[k]) begin
      errors++;
      $display("FAIL en_grant: seen=%0d gnt=%b i=%h j=%h, expected %b %h %h",
               seen, gnt, addr_i, addr_j, oh(k), ri[k], rj[k]);
    end
    fin_after(2);
    get_fin = 1'b0;
    checks++;
    if (done !== oh(k)) begin
      errors++;
      $display("FAIL en_done: done=%b, expected %b", done, oh(k));
    end
  endtask

  task automatic test_busy_pulse();
    bit seen;
    int k;
    int bad;
    req = 4'b0001;
    exp_q.push_back(0);
    wait_gnt(3, seen);
    k = exp_q.pop_front();
    req = '0;
    checks++;
    if (!seen || gnt !== oh(k)) begin
      errors++;
      $display("FAIL pulse_grant: seen=%0d gnt=%b, expected %b", seen, gnt, oh(k));
    end
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    fin_after(3);
    get_fin = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (gnt !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pulse_not_granted: grant cycles=%0d, expected 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int k;
    do_reset();
    req = 4'b0010;
    exp_q.push_back(1);
    wait_gnt(3, seen);
    k = exp_q.pop_front();
    req = '0;
    fin_after(2);
    get_fin = 1'b0;
    req = 4'b0100;
    exp_q.push_back(2);
    wait_gnt(3, seen);
    k = exp_q.pop_front();
    req = '0;
    checks++;
    if (!seen || gnt !== oh(k) || addr_i !== ri[k]) begin
      errors++;
      $display("FAIL rstmid_grant: seen=%0d gnt=%b i=%h, expected %b %h", seen, gnt, addr_i, oh(k), ri[k]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== '0 || done !== '0 || get_v !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
        addr_i !== '0 || addr_j !== '0 || act_id !== '0) begin
      errors++;
      $display("FAIL rstmid_async: gnt=%b done=%b get_v=%b busy=%b err=%b i=%h j=%h id=%0d, expected all zero",
               gnt, done, get_v, busy, err, addr_i, addr_j, act_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1010;
    exp_q.push_back(1);
    exp_q.push_back(3);
    for (int n = 0; n < 2; n++) begin
      wait_gnt(3, seen);
      k = exp_q.pop_front();
      checks++;
      if (!seen || gnt !== oh(k) || act_id !== IW'(k) || addr_i !== ri[k] || addr_j !== rj[k]) begin
        errors++;
        $display("FAIL rstmid_regrant%0d: seen=%0d gnt=%b id=%0d i=%h j=%h, expected %b %0d %h %h",
                 n, seen, gnt, act_id, addr_i, addr_j, oh(k), k, ri[k], rj[k]);
      end
      fin_after(2);
      get_fin = 1'b0;
      if (n == 1) req = '0;
      checks++;
      if (done !== oh(k)) begin
        errors++;
        $display("FAIL rstmid_done%0d: done=%b, expected %b", n, done, oh(k));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    en      = 1'b1;
    req     = '0;
    get_fin = 1'b0;
    clr_err = 1'b0;
    ri[0] = 20'd3;     rj[0] = 20'd5;
    ri[1] = 20'h1A2B3; rj[1] = 20'h0C0DE;
    ri[2] = 20'h55555; rj[2] = 20'hAAAAA;
    ri[3] = 20'd0;     rj[3] = 20'hFFFFF;

    test_reset();
    test_single();
    test_round_robin();
    test_rr_pointer();
    test_stale_fin();
    test_watchdog();
    test_en_gating();
    test_busy_pulse();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
